// File: rtl/la32_mem_pkg.sv
// Shared types and helpers for the LA32 MEM stage: memory op encoding,
// stage FSM states, the EX/MEM payload and op classification functions.
package la32_mem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RF_AW = 5;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LD_B     = 4'd1,
    LD_H     = 4'd2,
    LD_W     = 4'd3,
    LD_BU    = 4'd4,
    LD_HU    = 4'd5,
    ST_B     = 4'd6,
    ST_H     = 4'd7,
    ST_W     = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  sdata;
    mem_op_e          op;
    logic             rf_we;
    logic [RF_AW-1:0] rd;
  } ex_mem_pkt_t;

  function automatic logic is_load(input mem_op_e op);
    case (op)
      LD_B, LD_H, LD_W, LD_BU, LD_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    case (op)
      ST_B, ST_H, ST_W: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic mem_size_e size_of(input mem_op_e op);
    case (op)
      LD_B, LD_BU, ST_B: return SZ_BYTE;
      LD_H, LD_HU, ST_H: return SZ_HALF;
      default:           return SZ_WORD;
    endcase
  endfunction

  // Only real memory ops can be misaligned; encodings outside the table are treated as non-memory.
  function automatic logic misaligned(input mem_op_e op, input logic [1:0] off);
    if (!(is_load(op) || is_store(op))) return 1'b0;
    case (size_of(op))
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane logic: store strobes and lane replication, load lane
// extraction with sign/zero extension, and misalignment detection.
module mem_align_unit
  import la32_mem_pkg::*;
(
  input  mem_op_e           op_i,
  input  logic [1:0]        off_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic [XLEN-1:0]   rword_i,
  output logic [3:0]        wstrb_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   ldata_o,
  output logic              misalign_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = '0;
    if (is_store(op_i)) begin
      case (size_of(op_i))
        SZ_BYTE: begin
          wstrb_o = 4'b0001 << off_i;
          wdata_o = {4{sdata_i[7:0]}};
        end
        SZ_HALF: begin
          wstrb_o = 4'b0011 << off_i;
          wdata_o = {2{sdata_i[15:0]}};
        end
        default: begin
          wstrb_o = 4'b1111;
          wdata_o = sdata_i;
        end
      endcase
    end
  end

  // Lane selection uses the captured low address bits of the access.
  always_comb begin
    lane_b  = rword_i[{off_i, 3'b000} +: 8];
    lane_h  = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    ldata_o = rword_i;
    case (op_i)
      LD_B:    ldata_o = {{24{lane_b[7]}}, lane_b};
      LD_BU:   ldata_o = {24'h000000, lane_b};
      LD_H:    ldata_o = {{16{lane_h[15]}}, lane_h};
      LD_HU:   ldata_o = {16'h0000, lane_h};
      default: ldata_o = rword_i;
    endcase
  end

  assign misalign_o = misaligned(op_i, off_i);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the LA32 core: EX/MEM pipeline register, single-outstanding
// req/gnt/rvalid data-memory port, load/store alignment and forwarding info.
module mem_access_stage
  import la32_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               ex_valid,
  output logic               mem_allowin,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [XLEN-1:0]    ex_alu_result,
  input  logic [XLEN-1:0]    ex_store_data,
  input  logic [3:0]         ex_mem_op,
  input  logic               ex_rf_we,
  input  logic [RF_AW-1:0]   ex_rd,
  input  logic               flush,
  input  logic               wb_allowin,
  output logic               wb_valid,
  output logic [XLEN-1:0]    wb_pc,
  output logic [XLEN-1:0]    wb_result,
  output logic               wb_rf_we,
  output logic [RF_AW-1:0]   wb_rd,
  output logic               wb_ale,
  output logic [XLEN-1:0]    wb_badv,
  output logic               dmem_req,
  output logic [3:0]         dmem_wstrb,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               fwd_we,
  output logic [RF_AW-1:0]   fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic               fwd_pending
);

  mem_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  ex_mem_pkt_t      pkt_q,   pkt_d;
  logic [XLEN-1:0]  rbuf_q,  rbuf_d;

  mem_op_e          ex_op;
  logic             ex_is_mem;
  logic             ex_misalign;
  logic             ready_go;
  logic             drain;
  logic             accept;
  logic             fire;
  logic             ale;

  logic [3:0]       al_wstrb;
  logic [XLEN-1:0]  al_wdata;
  logic [XLEN-1:0]  al_ldata;
  logic             al_misalign;
  logic [XLEN-1:0]  al_rword;

  assign ex_op       = mem_op_e'(ex_mem_op);
  assign ex_is_mem   = is_load(ex_op) || is_store(ex_op);
  assign ex_misalign = misaligned(ex_op, ex_alu_result[1:0]);

  // Load data comes straight from the port in RESP, from the buffer once parked in DONE.
  assign al_rword = (state_q == S_DONE) ? rbuf_q : dmem_rdata;

  mem_align_unit u_align (
    .op_i       (pkt_q.op),
    .off_i      (pkt_q.addr[1:0]),
    .sdata_i    (pkt_q.sdata),
    .rword_i    (al_rword),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .ldata_o    (al_ldata),
    .misalign_o (al_misalign)
  );

  always_comb begin
    ready_go = 1'b0;
    case (state_q)
      S_IDLE:  ready_go = 1'b1;
      S_REQ:   ready_go = 1'b0;
      S_RESP:  ready_go = dmem_rvalid;
      S_DONE:  ready_go = 1'b1;
      default: ready_go = 1'b0;
    endcase
  end

  // A flushed access still waiting for its response blocks new work until it drains.
  assign drain       = (state_q == S_RESP) && !valid_q;
  assign mem_allowin = !drain && (!valid_q || (ready_go && wb_allowin));
  assign accept      = ex_valid && mem_allowin && !flush;
  assign fire        = valid_q && ready_go && wb_allowin;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pkt_d   = pkt_q;
    rbuf_d  = rbuf_q;
    if ((state_q == S_RESP) && dmem_rvalid) rbuf_d = dmem_rdata;
    if (flush) begin
      valid_d = 1'b0;
      case (state_q)
        S_REQ:   state_d = dmem_gnt    ? S_RESP : S_IDLE;
        S_RESP:  state_d = dmem_rvalid ? S_IDLE : S_RESP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_REQ:   if (dmem_gnt) state_d = S_RESP;
        S_RESP:  if (dmem_rvalid) state_d = valid_q ? S_DONE : S_IDLE;
        default: state_d = state_q;
      endcase
      if (fire) begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      if (accept) begin
        valid_d = 1'b1;
        pkt_d   = '{pc: ex_pc, addr: ex_alu_result, sdata: ex_store_data,
                    op: ex_op, rf_we: ex_rf_we, rd: ex_rd};
        state_d = (ex_is_mem && !ex_misalign) ? S_REQ : S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      pkt_q   <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
      rbuf_q  <= rbuf_d;
    end
  end

  assign ale         = valid_q && al_misalign;

  assign wb_valid    = valid_q && ready_go;
  assign wb_pc       = pkt_q.pc;
  assign wb_result   = (is_load(pkt_q.op) && !al_misalign) ? al_ldata : pkt_q.addr;
  assign wb_rf_we    = pkt_q.rf_we && !ale;
  assign wb_rd       = pkt_q.rd;
  assign wb_ale      = ale;
  assign wb_badv     = ale ? pkt_q.addr : '0;

  assign dmem_req    = (state_q == S_REQ);
  assign dmem_addr   = dmem_req ? {pkt_q.addr[XLEN-1:2], 2'b00} : '0;
  assign dmem_wstrb  = dmem_req ? al_wstrb : 4'b0000;
  assign dmem_wdata  = dmem_req ? al_wdata : '0;

  assign fwd_we      = valid_q && pkt_q.rf_we;
  assign fwd_rd      = pkt_q.rd;
  assign fwd_data    = wb_result;
  assign fwd_pending = fwd_we && is_load(pkt_q.op) && !ready_go;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single-access vectors with an
// ideal memory responder, plus hand sequences for stalls, buffering and flush.
module tb_mem_access_stage;
  import la32_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid;
  logic        mem_allowin;
  logic [31:0] ex_pc, ex_alu_result, ex_store_data;
  logic [3:0]  ex_mem_op;
  logic        ex_rf_we;
  logic [4:0]  ex_rd;
  logic        flush, wb_allowin;
  logic        wb_valid;
  logic [31:0] wb_pc, wb_result;
  logic        wb_rf_we;
  logic [4:0]  wb_rd;
  logic        wb_ale;
  logic [31:0] wb_badv;
  logic        dmem_req;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        fwd_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .mem_allowin(mem_allowin),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_op(ex_mem_op), .ex_rf_we(ex_rf_we), .ex_rd(ex_rd), .flush(flush),
    .wb_allowin(wb_allowin), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_result(wb_result),
    .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_ale(wb_ale), .wb_badv(wb_badv),
    .dmem_req(dmem_req), .dmem_wstrb(dmem_wstrb), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fwd_pending(fwd_pending)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        rf_we;
    logic        exp_req;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_result;
    logic        exp_ale;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  task automatic drive_ex(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic rf_we, input logic [31:0] pc);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_alu_result = addr;
    ex_store_data = sdata;
    ex_rf_we      = rf_we;
    ex_rd         = 5'd3;
    ex_pc         = pc;
  endtask

  // Accept in N, gnt in N+1, rvalid in N+2 with WB always ready.
  task automatic run_vec(input int idx);
    vec_t        v;
    logic [31:0] pc;
    string       t;
    v  = vecs[idx];
    pc = 32'h1C00_0000 + 32'(idx * 4);
    t  = $sformatf("v%0d", idx);
    @(negedge clk);
    drive_ex(v.op, v.addr, v.sdata, v.rf_we, pc);
    wb_allowin = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #1 chk({t, ".allowin"}, 32'(mem_allowin), 32'd1);
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    if (v.exp_req) begin
      chk({t, ".req"},   32'(dmem_req),   32'd1);
      chk({t, ".addr"},  dmem_addr,       v.exp_addr);
      chk({t, ".wstrb"}, 32'(dmem_wstrb), 32'(v.exp_wstrb));
      chk({t, ".wdata"}, dmem_wdata,      v.exp_wdata);
      chk({t, ".early_valid"}, 32'(wb_valid), 32'd0);
      chk({t, ".pending"}, 32'(fwd_pending), 32'(v.rf_we && op_is_load(v.op)));
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
      #1;
      chk({t, ".req_off"}, 32'(dmem_req), 32'd0);
      chk({t, ".wb_valid"}, 32'(wb_valid), 32'd1);
      chk({t, ".wb_pc"}, wb_pc, pc);
      chk({t, ".rf_we"}, 32'(wb_rf_we), 32'(v.rf_we));
      chk({t, ".ale"}, 32'(wb_ale), 32'd0);
      if (op_is_load(v.op)) begin
        chk({t, ".result"},  wb_result, v.exp_result);
        chk({t, ".fwd_data"}, fwd_data, v.exp_result);
      end
      @(negedge clk);
      dmem_rvalid = 1'b0;
    end else begin
      chk({t, ".no_req"},   32'(dmem_req), 32'd0);
      chk({t, ".wb_valid"}, 32'(wb_valid), 32'd1);
      chk({t, ".ale"},      32'(wb_ale),   32'(v.exp_ale));
      chk({t, ".rf_we"},    32'(wb_rf_we), 32'(v.rf_we && !v.exp_ale));
      if (v.exp_ale) chk({t, ".badv"}, wb_badv, v.addr);
      else           chk({t, ".result"}, wb_result, v.exp_result);
    end
  endtask

  initial begin
    vecs[0]  = '{LD_B,     32'h1003, 32'h0,        32'h80FF_1234, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0,        32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{LD_HU,    32'h1002, 32'h0,        32'h80FF_1234, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0,        32'h0000_80FF, 1'b0};
    vecs[2]  = '{LD_H,     32'h1002, 32'h0,        32'h80FF_1234, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0,        32'hFFFF_80FF, 1'b0};
    vecs[3]  = '{ST_H,     32'h2002, 32'h0000_ABCD, 32'h0,        1'b0, 1'b1, 4'hC, 32'h2000, 32'hABCD_ABCD, 32'h0,        1'b0};
    vecs[4]  = '{LD_W,     32'h3001, 32'h0,        32'h0,         1'b1, 1'b0, 4'h0, 32'h0,    32'h0,        32'h0,         1'b1};
    vecs[5]  = '{LD_BU,    32'h1003, 32'h0,        32'h80FF_1234, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0,        32'h0000_0080, 1'b0};
    vecs[6]  = '{ST_B,     32'h4001, 32'h1234_5678, 32'h0,        1'b0, 1'b1, 4'h2, 32'h4000, 32'h7878_7878, 32'h0,        1'b0};
    vecs[7]  = '{ST_W,     32'h5000, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b1, 4'hF, 32'h5000, 32'hDEAD_BEEF, 32'h0,        1'b0};
    vecs[8]  = '{LD_W,     32'h6004, 32'h0,        32'hCAFE_F00D, 1'b1, 1'b1, 4'h0, 32'h6004, 32'h0,        32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{MEM_NONE, 32'h1111_2222, 32'h0,   32'h0,         1'b1, 1'b0, 4'h0, 32'h0,    32'h0,        32'h1111_2222, 1'b0};
    vecs[10] = '{ST_H,     32'h2001, 32'h0000_ABCD, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        32'h0,         1'b1};
    vecs[11] = '{LD_H,     32'h1000, 32'h0,        32'h80FF_1234, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0,        32'h0000_1234, 1'b0};
    vecs[12] = '{LD_B,     32'h1001, 32'h0,        32'h80FF_1234, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0,        32'h0000_0012, 1'b0};
    vecs[13] = '{LD_H,     32'h1003, 32'h0,        32'h0,         1'b1, 1'b0, 4'h0, 32'h0,    32'h0,        32'h0,         1'b1};
    vecs[14] = '{ST_B,     32'h4003, 32'h0000_00A5, 32'h0,        1'b0, 1'b1, 4'h8, 32'h4000, 32'hA5A5_A5A5, 32'h0,        1'b0};

    rstn = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_alu_result = '0; ex_store_data = '0;
    ex_mem_op = 4'd0; ex_rf_we = 1'b0; ex_rd = '0; flush = 1'b0; wb_allowin = 1'b1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.wb_valid",    32'(wb_valid),    32'd0);
    chk("rst.dmem_req",    32'(dmem_req),    32'd0);
    chk("rst.fwd_we",      32'(fwd_we),      32'd0);
    chk("rst.fwd_pending", 32'(fwd_pending), 32'd0);
    chk("rst.wb_ale",      32'(wb_ale),      32'd0);
    chk("rst.wb_result",   wb_result,        32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i);

    // Load with gnt three cycles late and WB stalled when the response arrives.
    @(negedge clk);
    drive_ex(LD_H, 32'h1002, 32'h0, 1'b1, 32'h1C00_0100);
    wb_allowin = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      dmem_gnt = (c == 3);
      #1;
      chk($sformatf("stall.req%0d", c),  32'(dmem_req),    32'd1);
      chk($sformatf("stall.addr%0d", c), dmem_addr,        32'h1000);
      chk($sformatf("stall.wstrb%0d", c), 32'(dmem_wstrb), 32'd0);
      chk($sformatf("stall.pend%0d", c), 32'(fwd_pending), 32'd1);
      chk($sformatf("stall.allow%0d", c), 32'(mem_allowin), 32'd0);
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    #1;
    chk("stall.resp_req",  32'(dmem_req),    32'd0);
    chk("stall.resp_pend", 32'(fwd_pending), 32'd1);
    chk("stall.resp_wbv",  32'(wb_valid),    32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_1234;
    #1;
    chk("stall.rv_wbv",   32'(wb_valid),    32'd1);
    chk("stall.rv_pend",  32'(fwd_pending), 32'd0);
    chk("stall.rv_allow", 32'(mem_allowin), 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #1;
    chk("stall.done_wbv", 32'(wb_valid),  32'd1);
    chk("stall.done_res", wb_result,      32'hFFFF_80FF);
    chk("stall.done_fwd", fwd_data,       32'hFFFF_80FF);
    chk("stall.done_fwe", 32'(fwd_we),    32'd1);
    chk("stall.done_pend", 32'(fwd_pending), 32'd0);
    @(negedge clk);
    wb_allowin = 1'b1;
    #1;
    chk("stall.cons_wbv",   32'(wb_valid),    32'd1);
    chk("stall.cons_res",   wb_result,        32'hFFFF_80FF);
    chk("stall.cons_allow", 32'(mem_allowin), 32'd1);
    @(negedge clk);
    #1 chk("stall.after_wbv", 32'(wb_valid), 32'd0);

    // Flush while waiting for the response: drain and discard it.
    @(negedge clk);
    drive_ex(LD_W, 32'h6000, 32'h0, 1'b1, 32'h1C00_0200);
    @(negedge clk);
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; flush = 1'b1;
    #1 chk("flush.resp_allow", 32'(mem_allowin), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush.drain_wbv",   32'(wb_valid),    32'd0);
    chk("flush.drain_allow", 32'(mem_allowin), 32'd0);
    chk("flush.drain_fwe",   32'(fwd_we),      32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    #1;
    chk("flush.rv_wbv",   32'(wb_valid),    32'd0);
    chk("flush.rv_allow", 32'(mem_allowin), 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    chk("flush.idle_allow", 32'(mem_allowin), 32'd1);
    chk("flush.idle_wbv",   32'(wb_valid),    32'd0);
    run_vec(0);

    // Flush beats a simultaneous EX offer.
    @(negedge clk);
    drive_ex(MEM_NONE, 32'h7777_0000, 32'h0, 1'b1, 32'h1C00_0300);
    flush = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    #1;
    chk("fprio.wbv", 32'(wb_valid), 32'd0);
    chk("fprio.fwe", 32'(fwd_we),   32'd0);

    // Flush before gnt drops the request.
    @(negedge clk);
    drive_ex(LD_W, 32'h6000, 32'h0, 1'b1, 32'h1C00_0400);
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b1;
    #1 chk("freq.req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("freq.req_off", 32'(dmem_req),    32'd0);
    chk("freq.wbv",     32'(wb_valid),    32'd0);
    chk("freq.allow",   32'(mem_allowin), 32'd1);
    run_vec(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
